// File: rtl/mem_access_pkg.sv
// Shared constants for the memory access unit: access size codes and FSM state encoding.
package mem_access_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: extracts/extends load data from a memory word and
// merges right-justified store data into the old word for sub-word stores.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // Offset 0 is the most significant byte, so the lane shift is (3 - offset) * 8.
        w_shift     = {~i_offset, 3'b000};
        w_byte      = i_word[w_shift +: 8];
        w_half      = i_offset[1] ? i_word[15:0] : i_word[31:16];
        o_load_data = i_word;
        o_merged    = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data              = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_merged                 = i_word;
                o_merged[w_shift +: 8]   = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_merged    = i_word;
                if (i_offset[1]) begin
                    o_merged[15:0] = i_wdata[15:0];
                end else begin
                    o_merged[31:16] = i_wdata[15:0];
                end
            end
            default: begin
                o_load_data = i_word;
                o_merged    = i_wdata;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a word-only data memory with fixed strobe latency.
// Sub-word stores run as read-modify-write; errors respond without touching memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int MEM_WORDS   = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_rd,
    output logic        mem_wr,
    output state_t      o_dbg_state
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data_in;
    logic        r_mem_rd;
    logic        r_mem_wr;

    logic [31:0] w_word_idx;
    logic        w_req_ok;
    logic        w_last;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_word_idx = {2'b00, req_addr[31:2]};
    assign w_last     = (r_cnt == CNT_LAST);

    always_comb begin
        w_req_ok = (req_size != SZ_ILL)
                && !(req_size == SZ_HALF && req_addr[0])
                && !(req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                && (w_word_idx < 32'(MEM_WORDS));
    end

    mem_lane_align u_lane (
        .i_offset    (r_offset),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_word      (mem_data_out),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_size        <= SZ_BYTE;
            r_unsigned    <= 1'b0;
            r_offset      <= 2'b00;
            r_wdata       <= '0;
            r_ready       <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= '0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        r_ready    <= 1'b0;
                        r_cnt      <= '0;
                        if (!w_req_ok) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (req_we && req_size == SZ_WORD) begin
                            r_state       <= ST_WR;
                            r_mem_wr      <= 1'b1;
                            r_mem_addr    <= w_word_idx;
                            r_mem_data_in <= req_wdata;
                        end else begin
                            r_state    <= ST_RD;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= w_word_idx;
                        end
                    end
                end
                ST_RD: begin
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_mem_rd <= 1'b0;
                        // Sub-word store: hand the merged word straight to the write phase.
                        if (r_we) begin
                            r_state       <= ST_WR;
                            r_mem_wr      <= 1'b1;
                            r_mem_data_in <= w_merged;
                        end else begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= w_load_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_mem_wr     <= 1'b0;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ready  <= 1'b1;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a word-array reference
// model and a simple 2-cycle-strobe data memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int MEM_WORDS = 40;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_rd;
  logic        mem_wr;
  state_t      dbg_state;

  mem_access_unit #(.MEM_LATENCY(2), .MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory model
  logic [31:0] bench_mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  assign mem_data_out = (mem_rd && mem_addr < MEM_WORDS) ? bench_mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_wr && mem_addr < MEM_WORDS) bench_mem[mem_addr[5:0]] <= mem_data_in;
  end

  // scoreboard state
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_total = 0;
  int   n_pass = 0;
  int   ncyc = 0;
  int   viol = 0;
  int   wr_total = 0;
  int   cur_rd = 0;
  int   cur_wr = 0;
  bit   in_flight = 0;
  bit   prev_strobe = 0;
  bit   prev_wr = 0;
  logic [31:0] prev_addr = 0;
  logic [31:0] prev_din = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got event missing expected event seen", name);
  endtask

  // reference model: whole-word array, big-endian byte numbering
  function automatic exp_t ref_access(input bit we, input int size, input bit uns,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int idx, off, sh;
    logic [31:0] w, mask, v;
    e.err = 0; e.rdata = 0; e.lat = 0; e.nrd = 0; e.nwr = 0;
    if (size == 3 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0) ||
        addr / 4 >= MEM_WORDS) begin
      e.err = 1; e.lat = 1;
      return e;
    end
    idx = int'(addr / 4);
    off = int'(addr % 4);
    w = ref_mem[idx];
    sh = (size == 0) ? 8 * (3 - off) : 16 * (1 - off / 2);
    if (!we) begin
      e.lat = 3; e.nrd = 2;
      if (size == 2) e.rdata = w;
      else if (size == 0) begin
        v = (w >> sh) & 32'hFF;
        e.rdata = (!uns && v >= 128) ? v - 32'd256 : v;
      end else begin
        v = (w >> sh) & 32'hFFFF;
        e.rdata = (!uns && v >= 32768) ? v - 32'd65536 : v;
      end
    end else if (size == 2) begin
      ref_mem[idx] = wdata;
      e.lat = 3; e.nwr = 2;
    end else begin
      mask = ((size == 0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
      e.lat = 5; e.nrd = 2; e.nwr = 2;
    end
    return e;
  endfunction

  // driver: present a request, wait for acceptance, push the expected response
  task automatic issue(input bit we, input int size, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit keep_valid);
    int t = 0;
    req_we = we; req_size = 2'(size); req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 100);
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(ref_access(we, size, uns, addr, wdata));
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      in_flight = 0;
      prev_strobe = 0;
      prev_wr = 0;
    end else begin
      exp_t e;
      int a;
      ncyc++;
      if (mem_rd && mem_wr) viol++;
      if (!resp_valid && (resp_err || resp_rdata != 0)) viol++;
      if ((mem_rd || mem_wr) && prev_strobe && mem_addr != prev_addr) viol++;
      if (mem_wr && prev_wr && mem_data_in != prev_din) viol++;
      if (mem_rd) cur_rd++;
      if (mem_wr) begin
        cur_wr++;
        wr_total++;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_latency", 32'(ncyc - a), 32'(e.lat));
          check("rd_cycles", 32'(cur_rd), 32'(e.nrd));
          check("wr_cycles", 32'(cur_wr), 32'(e.nwr));
        end
        in_flight = 0;
      end
      if (req_valid && req_ready) begin
        check("accept_only_when_idle", 32'(in_flight), 32'd0);
        acc_q.push_back(ncyc);
        in_flight = 1;
        cur_rd = 0;
        cur_wr = 0;
      end
      prev_strobe = mem_rd || mem_wr;
      prev_wr = mem_wr;
      prev_addr = mem_addr;
      prev_din = mem_data_in;
    end
  end

  // stimulus
  initial begin
    int wr_before;
    logic [31:0] saved;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      bench_mem[i] = $urandom;
      ref_mem[i] = bench_mem[i];
    end
    bench_mem[5] = 32'h8899AABB;
    ref_mem[5] = 32'h8899AABB;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_mem_wr", 32'(mem_wr), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_data_in", mem_data_in, 32'd0);
    @(posedge clk);
    #1;

    // directed accesses on word 5
    issue(0, 2, 0, 32'h14, 32'h0, 0);
    issue(0, 0, 0, 32'h15, 32'h0, 0);
    issue(0, 0, 1, 32'h15, 32'h0, 0);
    issue(0, 1, 1, 32'h16, 32'h0, 0);
    issue(1, 0, 0, 32'h17, 32'h11, 0);
    wait_idle();
    check("sb_mem5", bench_mem[5], 32'h8899AA11);

    // error cases
    issue(0, 2, 0, 32'h16, 32'h0, 0);
    issue(0, 1, 0, 32'h13, 32'h0, 0);
    issue(0, 2, 0, 32'hA0, 32'h0, 0);
    issue(0, 3, 0, 32'h10, 32'h0, 0);
    wait_idle();

    // reset during the second read cycle of a halfword store
    saved = ref_mem[5];
    wr_before = wr_total;
    req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h14; req_wdata = 32'hCAFE;
    req_valid = 1'b1;
    @(negedge clk);
    check("rst_test_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_abort_no_wr", 32'(wr_total), 32'(wr_before));
    check("rst_abort_mem5", bench_mem[5], saved);
    check("rst_abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // back-to-back with valid held high
    issue(0, 2, 0, 32'h20, 32'h0, 1);
    issue(0, 2, 0, 32'h24, 32'h0, 0);
    wait_idle();

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      int r, sz;
      logic [31:0] addr;
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      addr = $urandom_range(0, 41 * 4 + 3);
      if (sz == 1 && $urandom_range(0, 3) != 0) addr[0] = 1'b0;
      if (sz == 2 && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("protocol_violations", 32'(viol), 32'd0);
    for (int i = 0; i < MEM_WORDS; i++) check("final_mem", bench_mem[i], ref_mem[i]);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
